branch_predict_unit: RTL and testbench

Parametrised successor to the combinational branch comparator: resolves branches/jumps in EX using the same 5-bit BrOp encoding, and adds a bimodal branch history table (BHT) of 2-bit saturating counters that predicts in fetch. Detects mispredictions and issues a registered redirect to the PC mux. Keeps saturating performance counters. Sits between fetch (lookup) and execute (resolve/update) in the RV32I core.

---
 rtl/branch_pkg.sv | 48 ++++
 rtl/branch_cmp.sv | 59 +++++
 rtl/branch_predict_unit.sv | 103 ++++++++++
 tb/tb_branch_predict_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions: BrOp codes, 2-bit BHT counter states, helpers.
// Imported by the comparator and by the predictor top.
package branch_pkg;

  localparam logic [4:0] BR_EQ  = 5'b01000;
  localparam logic [4:0] BR_NE  = 5'b01001;
  localparam logic [4:0] BR_LT  = 5'b01100;
  localparam logic [4:0] BR_GE  = 5'b01101;
  localparam logic [4:0] BR_LTU = 5'b01110;
  localparam logic [4:0] BR_GEU = 5'b01111;

  localparam int PC_W = 64;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_state_e;

  // Word address; callers keep the low IDX_W bits as the table index.
  function automatic logic [PC_W-1:0] bht_index(
    input logic [PC_W-1:0] pc
  );
    return pc >> 2;
  endfunction

  function automatic cnt_state_e cnt_next(
    input cnt_state_e s,
    input logic       taken
  );
    cnt_state_e n;
    n = s;
    unique case (s)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

  function automatic logic cnt_pred(input cnt_state_e s);
    return s >= WT;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational BrOp decode and operand compare.
// Flags jumps and the six conditional branch codes separately.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      brop,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            is_jump,
  output logic            is_cond
);

  logic eq, lt, ltu;

  assign eq  = rs1 == rs2;
  assign lt  = $signed(rs1) < $signed(rs2);
  assign ltu = rs1 < rs2;

  always_comb begin
    taken   = 1'b0;
    is_jump = 1'b0;
    is_cond = 1'b0;
    unique case (1'b1)
      brop[4]: begin
        taken   = 1'b1;
        is_jump = 1'b1;
      end
      brop == BR_EQ: begin
        taken   = eq;
        is_cond = 1'b1;
      end
      brop == BR_NE: begin
        taken   = !eq;
        is_cond = 1'b1;
      end
      brop == BR_LT: begin
        taken   = lt;
        is_cond = 1'b1;
      end
      brop == BR_GE: begin
        taken   = !lt;
        is_cond = 1'b1;
      end
      brop == BR_LTU: begin
        taken   = ltu;
        is_cond = 1'b1;
      end
      brop == BR_GEU: begin
        taken   = !ltu;
        is_cond = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal BHT predictor with EX-stage resolve, registered redirect
// and saturating branch/mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [4:0]       ex_brop,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             br_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  cnt_state_e bht [BHT_ENTRIES];

  logic [PC_W-1:0]  f_word;
  logic [PC_W-1:0]  ex_word;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;

  logic taken, is_jump, is_cond;
  logic qual, mispredict, counted;

  assign f_word  = bht_index(PC_W'(f_pc));
  assign ex_word = bht_index(PC_W'(ex_pc));
  assign f_idx   = f_word[IDX_W-1:0];
  assign ex_idx  = ex_word[IDX_W-1:0];

  assign f_pred_taken = cnt_pred(bht[f_idx]);

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .brop    (ex_brop),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .taken   (taken),
    .is_jump (is_jump),
    .is_cond (is_cond)
  );

  // Op right after a redirect is on the wrong path and is dropped.
  assign qual       = ex_valid && !redirect_valid;
  assign mispredict = qual && (taken != ex_pred_taken);
  assign counted    = qual && (is_jump || is_cond);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= WNT;
      end
    end else if (qual && is_cond) begin
      bht[ex_idx] <= cnt_next(bht[ex_idx], taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_taken       <= 1'b0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= taken ? ex_target : ex_pc + XLEN'(4);
      end
      if (qual) begin
        br_taken <= taken;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (counted && branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && mispredict_cnt != '1) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table plus
// shadow, same-cycle lookup, saturation and async reset sequences.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [XLEN-1:0]  f_pc;
  logic             f_pred_taken;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [4:0]       ex_brop;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             br_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  int checks;
  int failures;
  int exp_bc;
  int exp_mc;

  branch_predict_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (64),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_pc           (f_pc),
    .f_pred_taken   (f_pred_taken),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_brop        (ex_brop),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_taken       (br_taken),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tgt;
    logic        pred;
    logic        rv;
    logic [31:0] rpc;
    logic        tk;
    logic        cnt;
  } vec_t;

  vec_t tv [12];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  task automatic check_cnts(input string nm);
    check({nm, ".branch_cnt"}, 32'(branch_cnt), sat(exp_bc));
    check({nm, ".mispredict_cnt"}, 32'(mispredict_cnt), sat(exp_mc));
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] t, input logic p);
    ex_pc         = pc;
    ex_brop       = op;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_target     = t;
    ex_pred_taken = p;
    ex_valid      = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    f_pc = pc;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_bc = 0;
    exp_mc = 0;
    rst_n = 1'b0;
    f_pc = '0;
    ex_valid = 1'b0;
    ex_pc = '0;
    ex_brop = '0;
    ex_rs1 = '0;
    ex_rs2 = '0;
    ex_target = '0;
    ex_pred_taken = 1'b0;

    tv[0]  = '{32'h40, 5'b01000, 32'd5, 32'd5, 32'h80,
               1'b0, 1'b1, 32'h80, 1'b1, 1'b1};
    tv[1]  = '{32'h44, 5'b01100, 32'hFFFFFFFF, 32'd1, 32'h90,
               1'b1, 1'b0, 32'h0, 1'b1, 1'b1};
    tv[2]  = '{32'h48, 5'b01110, 32'hFFFFFFFF, 32'd1, 32'h90,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    tv[3]  = '{32'h4C, 5'b01111, 32'hFFFFFFFF, 32'd1, 32'h90,
               1'b1, 1'b0, 32'h0, 1'b1, 1'b1};
    tv[4]  = '{32'h50, 5'b01001, 32'd1, 32'd2, 32'hA0,
               1'b1, 1'b0, 32'h0, 1'b1, 1'b1};
    tv[5]  = '{32'h54, 5'b01101, 32'hFFFFFFFF, 32'd1, 32'hA4,
               1'b1, 1'b1, 32'h58, 1'b0, 1'b1};
    tv[6]  = '{32'h58, 5'b01001, 32'd7, 32'd7, 32'hB0,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    tv[7]  = '{32'h100, 5'b10000, 32'd0, 32'd0, 32'h200,
               1'b0, 1'b1, 32'h200, 1'b1, 1'b1};
    tv[8]  = '{32'h104, 5'b11111, 32'd0, 32'd0, 32'h300,
               1'b1, 1'b0, 32'h0, 1'b1, 1'b1};
    tv[9]  = '{32'h60, 5'b01010, 32'd3, 32'd4, 32'h70,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tv[10] = '{32'h64, 5'b01010, 32'd3, 32'd3, 32'h70,
               1'b1, 1'b1, 32'h68, 1'b0, 1'b0};
    tv[11] = '{32'hFFFFFFFC, 5'b01001, 32'd9, 32'd9, 32'h10,
               1'b1, 1'b1, 32'h0, 1'b0, 1'b1};

    #1;
    check("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'd0);
    check("rst.br_taken", 32'(br_taken), 32'd0);
    check_cnts("rst");
    for (int p = 0; p < 256; p += 4) begin
      lookup(32'(p));
      check($sformatf("rst.pred_%0h", p), 32'(f_pred_taken), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 12; i++) begin
      resolve(tv[i].pc, tv[i].op, tv[i].a, tv[i].b, tv[i].tgt,
              tv[i].pred);
      if (tv[i].cnt) exp_bc++;
      if (tv[i].rv) exp_mc++;
      check($sformatf("v%0d.redirect_valid", i),
            32'(redirect_valid), 32'(tv[i].rv));
      if (tv[i].rv) begin
        check($sformatf("v%0d.redirect_pc", i), redirect_pc, tv[i].rpc);
      end
      check($sformatf("v%0d.br_taken", i), 32'(br_taken), 32'(tv[i].tk));
      check_cnts($sformatf("v%0d", i));
      idle();
      check($sformatf("v%0d.pulse_end", i), 32'(redirect_valid), 32'd0);
    end

    lookup(32'h40);
    check("bht.beq_wt", 32'(f_pred_taken), 32'd1);
    lookup(32'h44);
    check("bht.blt_wt", 32'(f_pred_taken), 32'd1);
    lookup(32'h48);
    check("bht.bltu_snt", 32'(f_pred_taken), 32'd0);
    lookup(32'h100);
    check("bht.jump_noupd", 32'(f_pred_taken), 32'd0);

    // Wrong-path shadow: second op would mispredict if it were taken up.
    resolve(32'h10, 5'b00000, 32'd0, 32'd0, 32'h99, 1'b1);
    exp_mc++;
    check("shadow.redirect_valid", 32'(redirect_valid), 32'd1);
    check("shadow.redirect_pc", redirect_pc, 32'h14);
    check("shadow.br_taken", 32'(br_taken), 32'd0);
    ex_pc = 32'h20;
    ex_brop = 5'b01000;
    ex_rs1 = 32'd1;
    ex_rs2 = 32'd1;
    ex_target = 32'h99;
    ex_pred_taken = 1'b0;
    ex_valid = 1'b1;
    idle();
    ex_valid = 1'b0;
    check("shadow.ignored_rv", 32'(redirect_valid), 32'd0);
    check("shadow.ignored_tk", 32'(br_taken), 32'd0);
    check_cnts("shadow");
    lookup(32'h20);
    check("shadow.no_bht", 32'(f_pred_taken), 32'd0);
    idle();

    // Same-cycle lookup and update of one entry sees the old state.
    f_pc = 32'h80;
    ex_pc = 32'h80;
    ex_brop = 5'b01000;
    ex_rs1 = 32'd2;
    ex_rs2 = 32'd2;
    ex_target = 32'h300;
    ex_pred_taken = 1'b0;
    ex_valid = 1'b1;
    #1;
    check("bypass.pre", 32'(f_pred_taken), 32'd0);
    idle();
    ex_valid = 1'b0;
    exp_bc++;
    exp_mc++;
    check("bypass.post", 32'(f_pred_taken), 32'd1);
    check("bypass.redirect_pc", redirect_pc, 32'h300);
    idle();

    for (int k = 0; k < 4; k++) begin
      resolve(32'h30, 5'b01001, 32'd1, 32'd2, 32'h90, 1'b1);
      exp_bc++;
      idle();
    end
    lookup(32'h30);
    check("sat.st_pred", 32'(f_pred_taken), 32'd1);
    resolve(32'h30, 5'b01001, 32'd4, 32'd4, 32'h90, 1'b1);
    exp_bc++;
    exp_mc++;
    check("sat.nt_redirect_pc", redirect_pc, 32'h34);
    idle();
    check("sat.wt_pred", 32'(f_pred_taken), 32'd1);
    check_cnts("sat");
    resolve(32'h30, 5'b01001, 32'd1, 32'd2, 32'h90, 1'b1);
    check("prerst.br_taken", 32'(br_taken), 32'd1);

    // Async reset lands mid-cycle with a mispredicting op pending.
    ex_pc = 32'h30;
    ex_brop = 5'b01001;
    ex_rs1 = 32'd6;
    ex_rs2 = 32'd6;
    ex_pred_taken = 1'b1;
    ex_valid = 1'b1;
    f_pc = 32'h40;
    #2;
    rst_n = 1'b0;
    #1;
    exp_bc = 0;
    exp_mc = 0;
    check("arst.pred_40", 32'(f_pred_taken), 32'd0);
    check("arst.redirect_valid", 32'(redirect_valid), 32'd0);
    check("arst.redirect_pc", redirect_pc, 32'd0);
    check("arst.br_taken", 32'(br_taken), 32'd0);
    check_cnts("arst");
    lookup(32'h30);
    check("arst.pred_30", 32'(f_pred_taken), 32'd0);
    idle();
    check("arst.held_rv", 32'(redirect_valid), 32'd0);
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("arst.discard_rv", 32'(redirect_valid), 32'd0);
    check_cnts("arst.after");

    for (int k = 0; k < 17; k++) begin
      resolve(32'h200, 5'b10000, 32'd0, 32'd0, 32'h400, 1'b0);
      exp_bc++;
      exp_mc++;
      idle();
    end
    check("cntsat.branch_cnt", 32'(branch_cnt), 32'd15);
    check("cntsat.mispredict_cnt", 32'(mispredict_cnt), 32'd15);
    check_cnts("cntsat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
